// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: per-channel synchroniser, debouncer, edge-selected
// one-cycle pulse and wrapping pulse counter.
module edge_detect_multi #(
    parameter int   CH     = 4,
    parameter int   SYNC   = 2,
    parameter int   DB_CYC = 4,
    parameter int   CNT_W  = 8,
    parameter logic INIT   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH-1:0]         y,
    input  logic [1:0]            mode,
    input  logic                  clr,
    output logic [CH-1:0]         level,
    output logic [CH-1:0]         p,
    output logic                  any_p,
    output logic [CH*CNT_W-1:0]   cnt
);

    localparam int              DC_W    = $clog2(DB_CYC) + 1;
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(DB_CYC - 1);

    typedef enum logic [1:0] {
        MODE_RISE = 2'b00,
        MODE_FALL = 2'b01,
        MODE_BOTH = 2'b10,
        MODE_OFF  = 2'b11
    } mode_t;

    mode_t mode_sel;
    logic  rise_en;
    logic  fall_en;

    assign mode_sel = mode_t'(mode);

    always_comb begin
        rise_en = 1'b0;
        fall_en = 1'b0;
        case (mode_sel)
            MODE_RISE: rise_en = 1'b1;
            MODE_FALL: fall_en = 1'b1;
            MODE_BOTH: begin
                rise_en = 1'b1;
                fall_en = 1'b1;
            end
            default: ;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic [SYNC-1:0]  sync_reg;
            logic             s;
            logic [DC_W-1:0]  dc_reg;
            logic [DC_W-1:0]  dc_next;
            logic             level_reg;
            logic             level_next;
            logic             p_reg;
            logic             p_next;
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_reg <= {SYNC{INIT}};
                end else begin
                    sync_reg <= {sync_reg[SYNC-2:0], y[gi]};
                end
            end

            assign s = sync_reg[SYNC-1];

            // Accept a new level only after DB_CYC consecutive differing samples;
            // any sample matching the current level restarts the count.
            always_comb begin
                dc_next    = dc_reg;
                level_next = level_reg;
                p_next     = 1'b0;
                if (s == level_reg) begin
                    dc_next = '0;
                end else if (dc_reg == DC_LAST) begin
                    level_next = s;
                    dc_next    = '0;
                    p_next     = s ? rise_en : fall_en;
                end else begin
                    dc_next = dc_reg + DC_W'(1);
                end
            end

            // Clear wins over a simultaneous pulse.
            always_comb begin
                cnt_next = cnt_reg;
                if (clr) begin
                    cnt_next = '0;
                end else if (p_reg) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dc_reg    <= '0;
                    level_reg <= INIT;
                    p_reg     <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    dc_reg    <= dc_next;
                    level_reg <= level_next;
                    p_reg     <= p_next;
                    cnt_reg   <= cnt_next;
                end
            end

            assign level[gi]                 = level_reg;
            assign p[gi]                     = p_reg;
            assign cnt[gi*CNT_W +: CNT_W]    = cnt_reg;
        end
    endgenerate

    assign any_p = |p;

endmodule
